// File: rtl/test_tx_pkg.sv
// Shared definitions for the MAC test-traffic source.
// Holds the FSM state encoding, the PRBS31 polynomial taps and the payload
// mode encodings used by test_tx_gen and test_tx_prbs.
package test_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TX    = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // PRBS31: x^31 + x^28 + 1
    localparam int unsigned PRBS_LEN = 31;
    localparam int unsigned PRBS_TAP = 28;

    localparam logic MODE_PRBS = 1'b0;
    localparam logic MODE_CNT  = 1'b1;

    localparam int unsigned PKT_NUM_W = 16;

endpackage

// File: rtl/test_tx_prbs.sv
// PRBS31 word generator, DATA_WIDTH bits per advance.
// Ports:
//   clk, rst_n  clock, async active-low reset (state returns to SEED)
//   seed_load   reload SEED (wins over advance)
//   advance     step the LFSR by DATA_WIDTH bits
//   data_out    next DATA_WIDTH bits from the current state, MSB = oldest bit
module test_tx_prbs
    import test_tx_pkg::*;
#(
    parameter int unsigned         DATA_WIDTH = 32,
    parameter logic [PRBS_LEN-1:0] SEED       = 31'h55AA
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seed_load,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [PRBS_LEN-1:0] lfsr;
    logic [PRBS_LEN-1:0] lfsr_next;

    // Unrolled serial LFSR: the bit shifted out each step becomes the next data bit.
    always_comb begin
        logic [PRBS_LEN-1:0] s;
        s        = lfsr;
        data_out = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            data_out[DATA_WIDTH-1-i] = s[PRBS_LEN-1];
            s = {s[PRBS_LEN-2:0], s[PRBS_LEN-1] ^ s[PRBS_TAP-1]};
        end
        lfsr_next = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (seed_load) begin
            lfsr <= SEED;
        end else if (advance) begin
            lfsr <= lfsr_next;
        end
    end

endmodule

// File: rtl/test_tx_gen.sv
// MAC test-traffic source: packets of pkt_size words separated by pause_size
// idle cycles, PRBS31 or counter payload, valid/ready output handshake,
// optional packet-count limit with done flag.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   start                          run level; low = stop after current packet
//   mode                           0 PRBS, 1 counter (sampled in LOAD)
//   pkt_size, pause_size           packet length / gap (sampled in LOAD)
//   pkt_num                        packets per run, 0 = unlimited (sampled on IDLE exit)
//   mac_tx_data/valid/sof/eof      registered output word and framing
//   mac_tx_ready                   sink ready
//   done                           packet limit reached, held until start drops
// Build option TEST_TX_GEN_STAT_EN adds saturating stat_pkt_cnt / stat_stall_cnt.
module test_tx_gen
    import test_tx_pkg::*;
#(
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         CNT_WIDTH  = 16,
    parameter logic [PRBS_LEN-1:0] PRBS_SEED  = 31'h55AA
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [CNT_WIDTH-1:0]  pkt_size,
    input  logic [CNT_WIDTH-1:0]  pause_size,
    input  logic [PKT_NUM_W-1:0]  pkt_num,
    output logic [DATA_WIDTH-1:0] mac_tx_data,
    output logic                  mac_tx_valid,
    output logic                  mac_tx_sof,
    output logic                  mac_tx_eof,
    input  logic                  mac_tx_ready,
    output logic                  done
`ifdef TEST_TX_GEN_STAT_EN
    ,
    output logic [31:0]           stat_pkt_cnt,
    output logic [31:0]           stat_stall_cnt
`endif
);

    state_e                state, state_d;
    logic [CNT_WIDTH-1:0]  cnt, cnt_d;
    logic [CNT_WIDTH-1:0]  size_cur, size_cur_d;
    logic [CNT_WIDTH-1:0]  pause_cur, pause_cur_d;
    logic                  mode_cur, mode_cur_d;
    logic [PKT_NUM_W-1:0]  pkt_num_cur, pkt_num_cur_d;
    logic [PKT_NUM_W-1:0]  pkt_cnt, pkt_cnt_d;
    logic [DATA_WIDTH-1:0] pay_cnt, pay_cnt_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  valid_d, sof_d, eof_d, done_d;
    logic                  seed_load_c, advance_c, accept_c;
    logic [DATA_WIDTH-1:0] prbs_word;
    logic [CNT_WIDTH-1:0]  size_eff;

    assign accept_c = mac_tx_valid && mac_tx_ready;
    assign size_eff = (pkt_size == '0) ? CNT_WIDTH'(1) : pkt_size;

    // LFSR steps whenever a fresh word is loaded into the output register,
    // so a stalled word never consumes PRBS bits.
    test_tx_prbs #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEED       (PRBS_SEED)
    ) u_prbs (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load_c),
        .advance   (advance_c),
        .data_out  (prbs_word)
    );

    // End-of-packet decision shared by TX (no pause) and PAUSE.
    function automatic state_e after_pkt(input logic [PKT_NUM_W-1:0] sent,
                                         input logic [PKT_NUM_W-1:0] limit,
                                         input logic                 run);
        if ((limit != '0) && (sent == limit)) return ST_DONE;
        else if (run)                         return ST_LOAD;
        else                                  return ST_IDLE;
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        size_cur_d    = size_cur;
        pause_cur_d   = pause_cur;
        mode_cur_d    = mode_cur;
        pkt_num_cur_d = pkt_num_cur;
        pkt_cnt_d     = pkt_cnt;
        pay_cnt_d     = pay_cnt;
        data_d        = mac_tx_data;
        valid_d       = mac_tx_valid;
        sof_d         = mac_tx_sof;
        eof_d         = mac_tx_eof;
        seed_load_c   = 1'b0;
        advance_c     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    seed_load_c   = 1'b1;
                    pay_cnt_d     = '0;
                    pkt_cnt_d     = '0;
                    pkt_num_cur_d = pkt_num;
                    state_d       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mode_cur_d  = mode;
                size_cur_d  = size_eff;
                pause_cur_d = pause_size;
                if (start) begin
                    state_d   = ST_TX;
                    cnt_d     = '0;
                    valid_d   = 1'b1;
                    sof_d     = 1'b1;
                    eof_d     = (size_eff == CNT_WIDTH'(1));
                    data_d    = (mode == MODE_PRBS) ? prbs_word : pay_cnt;
                    advance_c = 1'b1;
                    pay_cnt_d = pay_cnt + DATA_WIDTH'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TX: begin
                if (accept_c) begin
                    if (mac_tx_eof) begin
                        valid_d   = 1'b0;
                        sof_d     = 1'b0;
                        eof_d     = 1'b0;
                        cnt_d     = '0;
                        pkt_cnt_d = pkt_cnt + PKT_NUM_W'(1);
                        if (pause_cur == '0) state_d = after_pkt(pkt_cnt_d, pkt_num_cur, start);
                        else                 state_d = ST_PAUSE;
                    end else begin
                        cnt_d     = cnt + CNT_WIDTH'(1);
                        sof_d     = 1'b0;
                        eof_d     = (cnt_d == size_cur - CNT_WIDTH'(1));
                        data_d    = (mode_cur == MODE_PRBS) ? prbs_word : pay_cnt;
                        advance_c = 1'b1;
                        pay_cnt_d = pay_cnt + DATA_WIDTH'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (cnt == pause_cur - CNT_WIDTH'(1)) state_d = after_pkt(pkt_cnt, pkt_num_cur, start);
                else                                  cnt_d   = cnt + CNT_WIDTH'(1);
            end
            ST_DONE: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        done_d = (state_d == ST_DONE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            size_cur     <= '0;
            pause_cur    <= '0;
            mode_cur     <= 1'b0;
            pkt_num_cur  <= '0;
            pkt_cnt      <= '0;
            pay_cnt      <= '0;
            mac_tx_data  <= '0;
            mac_tx_valid <= 1'b0;
            mac_tx_sof   <= 1'b0;
            mac_tx_eof   <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            size_cur     <= size_cur_d;
            pause_cur    <= pause_cur_d;
            mode_cur     <= mode_cur_d;
            pkt_num_cur  <= pkt_num_cur_d;
            pkt_cnt      <= pkt_cnt_d;
            pay_cnt      <= pay_cnt_d;
            mac_tx_data  <= data_d;
            mac_tx_valid <= valid_d;
            mac_tx_sof   <= sof_d;
            mac_tx_eof   <= eof_d;
            done         <= done_d;
        end
    end

`ifdef TEST_TX_GEN_STAT_EN
    // Saturating statistics, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkt_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (accept_c && mac_tx_eof && (stat_pkt_cnt != '1))
                stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            if (mac_tx_valid && !mac_tx_ready && (stat_stall_cnt != '1))
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_test_tx_gen.sv
// Directed bench for test_tx_gen: 32-bit instance for framing/handshake,
// plus a 64-bit instance sharing the stimulus for the PRBS width check.
module tb_test_tx_gen;

    logic        clk = 1'b0;
    logic        rst_n, start, mode, ready;
    logic [15:0] pkt_size, pause_size, pkt_num;
    logic [31:0] data;
    logic        valid, sof, eof, done;
    logic [63:0] data64;
    logic        valid64, sof64, eof64, done64;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] wq[$];
    logic        sq[$];
    logic        eq[$];
    int          cq[$];
    logic [63:0] w64q[$];

    logic        rand_rdy   = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic        prev_s, prev_e;

    always #5 clk = ~clk;

    test_tx_gen #(.DATA_WIDTH(32), .CNT_WIDTH(16), .PRBS_SEED(31'h55AA)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .pkt_size(pkt_size), .pause_size(pause_size), .pkt_num(pkt_num),
        .mac_tx_data(data), .mac_tx_valid(valid), .mac_tx_sof(sof), .mac_tx_eof(eof),
        .mac_tx_ready(ready), .done(done)
    );

    test_tx_gen #(.DATA_WIDTH(64), .CNT_WIDTH(16), .PRBS_SEED(31'h55AA)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .pkt_size(pkt_size), .pause_size(pause_size), .pkt_num(pkt_num),
        .mac_tx_data(data64), .mac_tx_valid(valid64), .mac_tx_sof(sof64), .mac_tx_eof(eof64),
        .mac_tx_ready(ready), .done(done64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample 1 ns after the edge, check held words, pick ready, log accepts.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_stall) begin
            check("hold_valid", 64'(valid), 64'(1'b1));
            check("hold_data",  64'(data),  64'(prev_d));
            check("hold_sof",   64'(sof),   64'(prev_s));
            check("hold_eof",   64'(eof),   64'(prev_e));
        end
        ready      = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_stall = valid && !ready;
        prev_d     = data;
        prev_s     = sof;
        prev_e     = eof;
        if (valid && ready) begin
            wq.push_back(data);
            sq.push_back(sof);
            eq.push_back(eof);
            cq.push_back(cyc);
        end
        if (valid64 && ready) w64q.push_back(data64);
    endtask

    task automatic wait_words(input int n, input int budget);
        int k;
        k = 0;
        while (wq.size() < n && k < budget) begin
            step();
            k++;
        end
        if (wq.size() < n) check("word_timeout", 64'(wq.size()), 64'(n));
    endtask

    task automatic start_run(input logic m, input logic [15:0] sz, input logic [15:0] ps,
                             input logic [15:0] num);
        wq.delete(); sq.delete(); eq.delete(); cq.delete(); w64q.delete();
        mode = m; pkt_size = sz; pause_size = ps; pkt_num = num;
        start = 1'b1;
    endtask

    // Wait for done (bounded), then drop start and return to IDLE.
    task automatic finish_run(input string tag, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            step();
            k++;
        end
        check(tag, 64'(done), 64'(1'b1));
        start = 1'b0;
        step();
        step();
    endtask

    task automatic check_cnt_words(input string tag, input int n, input int psz);
        if (wq.size() >= n) begin
            for (int i = 0; i < n; i++) begin
                check($sformatf("%s_data%0d", tag, i), 64'(wq[i]), 64'(i));
                check($sformatf("%s_sof%0d", tag, i), 64'(sq[i]), 64'((i % psz) == 0));
                check($sformatf("%s_eof%0d", tag, i), 64'(eq[i]), 64'((i % psz) == psz - 1));
            end
        end
    endtask

    task automatic reset_now();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_sof",   64'(sof),   64'd0);
        check("rst_eof",   64'(eof),   64'd0);
        check("rst_data",  64'(data),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        start      = 1'b0;
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic prbs_check(input int width);
        logic [30:0] s;
        logic [63:0] w;
        logic [63:0] got;
        s = 31'h55AA;
        for (int i = 0; i < 100; i++) begin
            w = '0;
            for (int b = 0; b < width; b++) begin
                w = {w[62:0], s[30]};
                s = {s[29:0], s[30] ^ s[27]};
            end
            if (width == 32) got = (i < wq.size())   ? 64'(wq[i]) : 64'hx;
            else             got = (i < w64q.size()) ? w64q[i]    : 64'hx;
            check($sformatf("prbs%0d_w%0d", width, i), got, w);
        end
    endtask

    initial begin
        int k;
        rst_n = 1'b0; start = 1'b0; mode = 1'b1; ready = 1'b1;
        pkt_size = 16'd4; pause_size = 16'd2; pkt_num = 16'd3;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_sof",   64'(sof),   64'd0);
        check("reset_eof",   64'(eof),   64'd0);
        check("reset_data",  64'(data),  64'd0);
        check("reset_done",  64'(done),  64'd0);
        rst_n = 1'b1;
        step();

        // Basic: 3 packets of 4 counter words, pause 2
        start_run(1'b1, 16'd4, 16'd2, 16'd3);
        wait_words(12, 200);
        check_cnt_words("basic", 12, 4);
        if (cq.size() >= 12) begin
            check("gap_in_pkt",   64'(cq[1] - cq[0]), 64'd1);
            check("gap_between",  64'(cq[4] - cq[3]), 64'd4);
            check("gap_between2", 64'(cq[8] - cq[7]), 64'd4);
        end
        k = 0;
        while (!done && k < 20) begin
            step();
            k++;
        end
        check("done_latency", 64'(k), 64'd3);
        repeat (3) step();
        check("done_held",  64'(done),  64'(1'b1));
        check("done_valid", 64'(valid), 64'd0);
        check("done_words", 64'(wq.size()), 64'd12);
        start = 1'b0;
        step();
        check("done_clear", 64'(done), 64'd0);
        step();

        // Single-word packets, no pause
        start_run(1'b1, 16'd1, 16'd0, 16'd3);
        wait_words(3, 100);
        check_cnt_words("single1", 3, 1);
        if (cq.size() >= 2) check("gap_nopause", 64'(cq[1] - cq[0]), 64'd2);
        finish_run("single1_done", 20);

        start_run(1'b1, 16'd0, 16'd0, 16'd2);
        wait_words(2, 100);
        check_cnt_words("single0", 2, 1);
        finish_run("single0_done", 20);
        check("single0_words", 64'(wq.size()), 64'd2);

        // Backpressure
        rand_rdy = 1'b1;
        start_run(1'b1, 16'd5, 16'd1, 16'd4);
        wait_words(20, 800);
        rand_rdy = 1'b0;
        check_cnt_words("bp", 20, 5);
        finish_run("bp_done", 40);
        check("bp_words", 64'(wq.size()), 64'd20);

        // Stop mid-packet
        start_run(1'b1, 16'd8, 16'd2, 16'd0);
        wait_words(4, 100);
        start = 1'b0;
        repeat (20) step();
        check("stop_words", 64'(wq.size()), 64'd8);
        check_cnt_words("stop", 8, 8);
        check("stop_valid", 64'(valid), 64'd0);
        check("stop_done",  64'(done),  64'd0);

        // Reset mid-packet, counter restarts at 0
        start_run(1'b1, 16'd6, 16'd1, 16'd0);
        wait_words(3, 100);
        reset_now();
        start_run(1'b1, 16'd6, 16'd1, 16'd0);
        wait_words(6, 100);
        check_cnt_words("rst_cnt", 6, 6);
        start = 1'b0;
        repeat (20) step();

        // PRBS at 32 and 64 bits, after a mid-packet reset
        start_run(1'b0, 16'd10, 16'd1, 16'd0);
        wait_words(5, 100);
        reset_now();
        start_run(1'b0, 16'd10, 16'd1, 16'd0);
        wait_words(100, 400);
        start = 1'b0;
        prbs_check(32);
        prbs_check(64);
        repeat (30) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
